keycode_ctrl: RTL and testbench
===============================

KEYCODE_CTRL -- requirements
Module: keycode_ctrl

Interface
REQ-001 Parameter KEY_LEFT, default 8'h04 (HID 'A'): keycode for move left.
REQ-002 Parameter KEY_RIGHT, default 8'h07 (HID 'D'): keycode for move right.
REQ-003 Parameter KEY_FIRE, default 8'h2C (HID space): keycode for fire.
REQ-004 Parameter KEY_START, default 8'h28 (HID Enter): keycode for game start.
REQ-005 Parameter FIRE_COOLDOWN, default 30, range 0..255: frames between shots.
REQ-006 Port clk_clk, input, 1: single system clock, all logic on its rising edge.
REQ-007 Port reset_reset_n, input, 1: reset, synchronous and active-low.
REQ-008 Port keycode_export, input, 8: keycode written by Nios software, asynchronous to frame timing.
REQ-009 Port frame_tick, input, 1: one-cycle pulse once per video frame.
REQ-010 Port fire_ack, input, 1: bullet spawner accepts the pending shot.
REQ-011 Port move_left, output, 1: one-cycle left-move command.
REQ-012 Port move_right, output, 1: one-cycle right-move command.
REQ-013 Port fire_req, output, 1: shot request, held until acknowledged.
REQ-014 Port start_pulse, output, 1: one-cycle start command.

Function
REQ-015 keycode_export registered into key_q every cycle; all decoding uses key_q only (1-cycle input latency).
REQ-016 On the cycle after frame_tick=1: move_left=1 iff key_q==KEY_LEFT, move_right=1 iff key_q==KEY_RIGHT; both 0 on all other cycles; never both 1.
REQ-017 start_pulse=1 for exactly one cycle on the cycle after key_q transitions from !=KEY_START to ==KEY_START; held key gives no further pulses.
REQ-018 Flag armed: set when key_q!=KEY_FIRE; cleared when a shot is launched; shots require armed=1 (press-release-press, no autofire).
REQ-019 Fire FSM states: IDLE, REQ, COOL.
REQ-020 IDLE->REQ when key_q==KEY_FIRE and armed=1; fire_req=1 from the following cycle; armed cleared the same edge.
REQ-021 REQ: fire_req held 1 until fire_ack=1 sampled; then to COOL (or IDLE if FIRE_COOLDOWN=0); fire_req=0 the next cycle.
REQ-022 fire_ack in IDLE or COOL is ignored.
REQ-023 COOL: 8-bit counter loaded with FIRE_COOLDOWN on entry, decremented on each frame_tick; on frame_tick with counter==1, to IDLE.
REQ-024 Fire key pressed during REQ or COOL does not queue a shot; armed still follows REQ-018.
REQ-025 frame_tick and fire_ack in the same cycle: ack processed, COOL entered; that tick does not decrement the new count.
REQ-026 FSM, counter and armed logic are independent of move and start logic; simultaneous events never block each other.

Reset
REQ-027 reset_reset_n=0 at a rising edge forces: FSM=IDLE, counter=0, armed=0, key_q=8'h00, all outputs 0 from the next cycle.
REQ-028 Reset mid-REQ or mid-COOL abandons the shot; a fire key held through reset does not fire until released and pressed again.
REQ-029 Reset has priority over every simultaneous input event.

Verification
REQ-030 keycode=8'h04, three frame_ticks -> exactly three 1-cycle move_left pulses, each one cycle after its tick; move_right stays 0.
REQ-031 keycode=8'h2C held 100 frames, fire_ack 5 cycles after fire_req rises -> exactly one shot; fire_req high exactly 6 cycles.
REQ-032 Press 2C, ack, release, press within 10 frames (FIRE_COOLDOWN=30) -> no second fire_req until 30 frame_ticks after ack; then fire_req rises only if key held or re-pressed.
REQ-033 FIRE_COOLDOWN=0: press/ack/release/press -> second fire_req 2 cycles after re-press.
REQ-034 Assert reset during REQ with 2C held -> fire_req 0 next cycle; no fire_req after reset until key goes to 00 and back to 2C.
REQ-035 keycode 00->28 held 50 cycles, then 28->00->28 -> exactly two start_pulses, each one cycle wide.

Source files
------------

// File: rtl/keycode_ctrl.sv
// Keyboard-to-game command decoder: frame-synchronous move pulses, an edge-detected
// start pulse and a fire request FSM with press-release re-arming and frame cooldown.
module keycode_ctrl #(
   parameter logic [7:0] KEY_LEFT      = 8'h04,
   parameter logic [7:0] KEY_RIGHT     = 8'h07,
   parameter logic [7:0] KEY_FIRE      = 8'h2C,
   parameter logic [7:0] KEY_START     = 8'h28,
   parameter int         FIRE_COOLDOWN = 30
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic [7:0] keycode_export,
   input  logic       frame_tick,
   input  logic       fire_ack,
   output logic       move_left,
   output logic       move_right,
   output logic       fire_req,
   output logic       start_pulse,
   output logic [1:0] fire_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_COOL = 2'd2
   } fire_state_t;

   localparam logic [7:0] COOL_INIT = FIRE_COOLDOWN[7:0];

   logic [7:0]  key_q;
   logic        key_valid_q;
   logic        start_seen_q;
   logic        armed_q;
   logic        armed_d;
   logic        launch;
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;
   fire_state_t state_q;
   fire_state_t state_d;

   logic key_is_fire;
   logic key_is_start;

   assign key_is_fire  = (key_q == KEY_FIRE);
   assign key_is_start = (key_q == KEY_START);

   // Input capture, move and start decoding; independent of the fire path.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         key_q        <= 8'h00;
         key_valid_q  <= 1'b0;
         start_seen_q <= 1'b0;
         move_left    <= 1'b0;
         move_right   <= 1'b0;
         start_pulse  <= 1'b0;
      end else begin
         key_q        <= keycode_export;
         key_valid_q  <= 1'b1;
         start_seen_q <= key_is_start;
         move_left    <= frame_tick && (key_q == KEY_LEFT);
         move_right   <= frame_tick && (key_q == KEY_RIGHT);
         start_pulse  <= key_is_start && !start_seen_q;
      end
   end

   // key_q's reset value is not a real release, so it must not re-arm a held fire key.
   always_comb begin
      armed_d = armed_q;
      if (launch)
         armed_d = 1'b0;
      else if (key_valid_q && !key_is_fire)
         armed_d = 1'b1;
   end

   // Fire FSM: state register
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   // Handshake: fire_req stays high until fire_ack is sampled high while fire_req=1;
   // fire_ack at any other time is ignored.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      launch  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (key_is_fire && armed_q) begin
               state_d = S_REQ;
               launch  = 1'b1;
            end
         end
         S_REQ: begin
            if (fire_ack) begin
               cnt_d = COOL_INIT;
               if (COOL_INIT == 8'd0)
                  state_d = S_IDLE;
               else
                  state_d = S_COOL;
            end
         end
         S_COOL: begin
            if (frame_tick) begin
               if (cnt_q <= 8'd1) begin
                  state_d = S_IDLE;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Fire FSM: outputs
   always_comb begin
      fire_req   = (state_q == S_REQ);
      fire_state = state_q;
   end

endmodule

// File: tb/tb_keycode_ctrl.sv
// Bench for keycode_ctrl: a default-cooldown instance and a zero-cooldown instance
// share stimulus; observed pulse cycles are scored against expected cycle queues.
module tb_keycode_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] keycode;
   logic       frame_tick;
   logic       fire_ack;
   logic       move_left, move_right, fire_req, start_pulse;
   logic [1:0] fire_state;
   logic       move_left0, move_right0, fire_req0, start_pulse0;
   logic [1:0] fire_state0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fire_hi_cnt = 0;
   logic fire_prev = 1'b0;
   logic fire0_prev = 1'b0;

   logic [31:0] exp_q[$];
   logic [31:0] obs_left[$];
   logic [31:0] obs_right[$];
   logic [31:0] obs_start[$];
   logic [31:0] obs_fire[$];
   logic [31:0] obs_fire0[$];

   keycode_ctrl dut (
      .clk_clk(clk), .reset_reset_n(reset_n), .keycode_export(keycode),
      .frame_tick(frame_tick), .fire_ack(fire_ack),
      .move_left(move_left), .move_right(move_right), .fire_req(fire_req),
      .start_pulse(start_pulse), .fire_state(fire_state)
   );

   keycode_ctrl #(.FIRE_COOLDOWN(0)) dut0 (
      .clk_clk(clk), .reset_reset_n(reset_n), .keycode_export(keycode),
      .frame_tick(frame_tick), .fire_ack(fire_ack),
      .move_left(move_left0), .move_right(move_right0), .fire_req(fire_req0),
      .start_pulse(start_pulse0), .fire_state(fire_state0)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: record the cycle of every observed pulse / rising edge
   always @(negedge clk) begin
      if (move_left === 1'b1) obs_left.push_back(cyc);
      if (move_right === 1'b1) obs_right.push_back(cyc);
      if (start_pulse === 1'b1) obs_start.push_back(cyc);
      if (fire_req === 1'b1 && fire_prev !== 1'b1) obs_fire.push_back(cyc);
      if (fire_req0 === 1'b1 && fire0_prev !== 1'b1) obs_fire0.push_back(cyc);
      if (fire_req === 1'b1) fire_hi_cnt++;
      fire_prev  = fire_req;
      fire0_prev = fire_req0;
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick(input int gap);
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(gap);
   endtask

   task automatic clear_obs;
      exp_q.delete();
      obs_left.delete();
      obs_right.delete();
      obs_start.delete();
      obs_fire.delete();
      obs_fire0.delete();
      fire_hi_cnt = 0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; keycode = 8'h2C; frame_tick = 1'b1; fire_ack = 1'b1;
      step(3);
      frame_tick = 1'b0; fire_ack = 1'b0; keycode = 8'h00;
      step(1);
      @(negedge clk);
      checks++; if (move_left !== 1'b0) begin errors++; $display("FAIL reset_move_left got %b exp 0", move_left); end
      checks++; if (move_right !== 1'b0) begin errors++; $display("FAIL reset_move_right got %b exp 0", move_right); end
      checks++; if (fire_req !== 1'b0) begin errors++; $display("FAIL reset_fire_req got %b exp 0", fire_req); end
      checks++; if (start_pulse !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", start_pulse); end
      checks++; if (fire_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", fire_state); end
      checks++; if (fire_req0 !== 1'b0) begin errors++; $display("FAIL reset_fire_req0 got %b exp 0", fire_req0); end
      reset_n = 1'b1;
      step(3);
   endtask

   task automatic test_move;
      logic [31:0] e, o;
      keycode = 8'h04;
      step(2);
      clear_obs();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(cyc + 1);
         pulse_tick(3 + i);
      end
      step(3);
      checks++; if (obs_left.size() !== 3) begin errors++; $display("FAIL left_count got %0d exp 3", obs_left.size()); end
      while (exp_q.size() > 0 && obs_left.size() > 0) begin
         e = exp_q.pop_front(); o = obs_left.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL left_cycle got %0d exp %0d", o, e); end
      end
      checks++; if (obs_right.size() !== 0) begin errors++; $display("FAIL left_right_quiet got %0d exp 0", obs_right.size()); end
      clear_obs();
      keycode = 8'h07;
      step(2);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(cyc + 1);
         pulse_tick(4);
      end
      step(5);
      checks++; if (obs_right.size() !== 2) begin errors++; $display("FAIL right_count got %0d exp 2", obs_right.size()); end
      while (exp_q.size() > 0 && obs_right.size() > 0) begin
         e = exp_q.pop_front(); o = obs_right.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL right_cycle got %0d exp %0d", o, e); end
      end
      checks++; if (obs_left.size() !== 0) begin errors++; $display("FAIL right_left_quiet got %0d exp 0", obs_left.size()); end
   endtask

   task automatic test_fire_single;
      logic [31:0] e, o;
      keycode = 8'h00;
      step(3);
      clear_obs();
      keycode = 8'h2C;
      exp_q.push_back(cyc + 2);
      step(2);
      @(negedge clk);
      checks++; if (fire_req !== 1'b1) begin errors++; $display("FAIL fire_rise got %b exp 1", fire_req); end
      step(5);
      fire_ack = 1'b1;
      step(1);
      fire_ack = 1'b0;
      repeat (100) pulse_tick(3);
      step(3);
      checks++; if (fire_hi_cnt !== 6) begin errors++; $display("FAIL fire_width got %0d exp 6", fire_hi_cnt); end
      checks++; if (obs_fire.size() !== 1) begin errors++; $display("FAIL fire_single_count got %0d exp 1", obs_fire.size()); end
      while (exp_q.size() > 0 && obs_fire.size() > 0) begin
         e = exp_q.pop_front(); o = obs_fire.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL fire_single_cycle got %0d exp %0d", o, e); end
      end
      checks++; if (fire_state !== 2'd0) begin errors++; $display("FAIL fire_idle_after got %0d exp 0", fire_state); end
   endtask

   task automatic test_cooldown;
      logic [31:0] e, o;
      keycode = 8'h00;
      step(3);
      clear_obs();
      keycode = 8'h2C;
      exp_q.push_back(cyc + 2);
      step(2);
      fire_ack = 1'b1;
      step(1);
      fire_ack = 1'b0;
      keycode = 8'h00;
      pulse_tick(2);
      keycode = 8'h2C;
      pulse_tick(2);
      repeat (27) pulse_tick(3);
      @(negedge clk);
      checks++; if (fire_req !== 1'b0) begin errors++; $display("FAIL cool_29_fire got %b exp 0", fire_req); end
      checks++; if (obs_fire.size() !== 1) begin errors++; $display("FAIL cool_29_count got %0d exp 1", obs_fire.size()); end
      step(1);
      exp_q.push_back(cyc + 2);
      pulse_tick(3);
      // ack together with a tick: that tick must not count toward the new cooldown
      fire_ack = 1'b1; frame_tick = 1'b1;
      step(1);
      fire_ack = 1'b0; frame_tick = 1'b0;
      keycode = 8'h00;
      step(2);
      keycode = 8'h2C;
      step(2);
      repeat (29) pulse_tick(3);
      @(negedge clk);
      checks++; if (obs_fire.size() !== 2) begin errors++; $display("FAIL cool_same_tick_count got %0d exp 2", obs_fire.size()); end
      step(1);
      exp_q.push_back(cyc + 2);
      pulse_tick(3);
      fire_ack = 1'b1;
      step(1);
      fire_ack = 1'b0;
      keycode = 8'h00;
      repeat (40) pulse_tick(2);
      step(2);
      checks++; if (obs_fire.size() !== 3) begin errors++; $display("FAIL cool_total_count got %0d exp 3", obs_fire.size()); end
      while (exp_q.size() > 0 && obs_fire.size() > 0) begin
         e = exp_q.pop_front(); o = obs_fire.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL cool_cycle got %0d exp %0d", o, e); end
      end
   endtask

   task automatic test_cooldown_zero;
      logic [31:0] e, o;
      reset_n = 1'b0; keycode = 8'h00;
      step(2);
      reset_n = 1'b1;
      step(3);
      clear_obs();
      keycode = 8'h2C;
      exp_q.push_back(cyc + 2);
      step(2);
      fire_ack = 1'b1;
      step(1);
      fire_ack = 1'b0;
      keycode = 8'h00;
      step(2);
      keycode = 8'h2C;
      exp_q.push_back(cyc + 2);
      step(4);
      fire_ack = 1'b1;
      step(1);
      fire_ack = 1'b0;
      step(3);
      checks++; if (obs_fire0.size() !== 2) begin errors++; $display("FAIL cool0_count got %0d exp 2", obs_fire0.size()); end
      while (exp_q.size() > 0 && obs_fire0.size() > 0) begin
         e = exp_q.pop_front(); o = obs_fire0.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL cool0_cycle got %0d exp %0d", o, e); end
      end
   endtask

   task automatic test_reset_mid_req;
      logic [31:0] e, o;
      keycode = 8'h00;
      repeat (31) pulse_tick(1);
      step(2);
      clear_obs();
      keycode = 8'h2C;
      exp_q.push_back(cyc + 2);
      step(2);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (fire_req !== 1'b0) begin errors++; $display("FAIL rst_req_drop got %b exp 0", fire_req); end
      step(20);
      checks++; if (obs_fire.size() !== 1) begin errors++; $display("FAIL rst_held_count got %0d exp 1", obs_fire.size()); end
      keycode = 8'h00;
      step(3);
      keycode = 8'h2C;
      exp_q.push_back(cyc + 2);
      step(4);
      fire_ack = 1'b1;
      step(1);
      fire_ack = 1'b0;
      keycode = 8'h00;
      step(3);
      checks++; if (obs_fire.size() !== 2) begin errors++; $display("FAIL rst_repress_count got %0d exp 2", obs_fire.size()); end
      while (exp_q.size() > 0 && obs_fire.size() > 0) begin
         e = exp_q.pop_front(); o = obs_fire.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL rst_cycle got %0d exp %0d", o, e); end
      end
   endtask

   task automatic test_start;
      logic [31:0] e, o;
      keycode = 8'h00;
      step(3);
      clear_obs();
      keycode = 8'h28;
      exp_q.push_back(cyc + 2);
      step(50);
      keycode = 8'h00;
      step(3);
      keycode = 8'h28;
      exp_q.push_back(cyc + 2);
      step(5);
      keycode = 8'h00;
      step(3);
      checks++; if (obs_start.size() !== 2) begin errors++; $display("FAIL start_count got %0d exp 2", obs_start.size()); end
      while (exp_q.size() > 0 && obs_start.size() > 0) begin
         e = exp_q.pop_front(); o = obs_start.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL start_cycle got %0d exp %0d", o, e); end
      end
   endtask

   initial begin
      reset_n = 1'b0; keycode = 8'h00; frame_tick = 1'b0; fire_ack = 1'b0;
      test_reset();
      test_move();
      test_fire_single();
      test_cooldown();
      test_cooldown_zero();
      test_reset_mid_req();
      test_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
